// File: rtl/serial_word_tx.sv
// serial_word_tx
//   Parallel-to-serial word transmitter. A producer hands over WIDTH-bit
//   words on a valid/ready handshake; each word is shifted out one bit per
//   clock on dout with a dout_valid strobe and a last marker on the final
//   bit. A one-deep hold register lets a second word queue up behind the
//   one in flight so consecutive words stream with no idle cycle.
//
// Parameters
//   WIDTH      bits per word (>= 2)
//   MSB_FIRST  0: ld_data[0] goes first, 1: ld_data[WIDTH-1] goes first
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous reset, active low
//   ld_valid    producer presents a word on ld_data
//   ld_data     word to send, sampled only on the accepting edge
//   ld_ready    a word can be accepted this cycle (= hold register empty)
//   dout        current serial bit (0 when dout_valid is 0)
//   dout_valid  dout carries a frame bit
//   last        dout is the final bit of the current word
//   busy        shifting, or a word is waiting in the hold register
module serial_word_tx #(
  parameter int WIDTH     = 11,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             last,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // State
  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_bitcnt;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;

  // Registered outputs
  logic             r_dout;
  logic             r_dout_valid;
  logic             r_last;
  logic             r_busy;

  // Next-state
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CW-1:0]    w_bitcnt_nxt;
  logic [WIDTH-1:0] w_hold_nxt;
  logic             w_hold_full_nxt;

  logic             w_accept;
  logic             w_end_of_word;
  logic [WIDTH-1:0] w_shift_adv;
  logic             w_head_nxt;

  // Ready depends only on the hold flop, so there is no combinational
  // path from ld_valid back to ld_ready.
  assign ld_ready      = ~r_hold_full;
  assign w_accept      = ld_valid & ~r_hold_full;
  assign w_end_of_word = (r_state == S_SHIFT) && (r_bitcnt == LAST_CNT);

  // The bit on dout is always the head of the shift register; advancing
  // moves the next bit into the head position.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shift_adv = {r_shift[WIDTH-2:0], 1'b0};
      assign w_head_nxt  = w_shift_nxt[WIDTH-1];
    end else begin : g_lsb_first
      assign w_shift_adv = {1'b0, r_shift[WIDTH-1:1]};
      assign w_head_nxt  = w_shift_nxt[0];
    end
  endgenerate

  // Next-state logic
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_bitcnt_nxt    = r_bitcnt;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;

    unique case (r_state)
      S_IDLE: begin
        // Hold is always empty in IDLE, so an accept goes straight to
        // the shift register.
        if (w_accept) begin
          w_shift_nxt  = ld_data;
          w_bitcnt_nxt = '0;
          w_state_nxt  = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (w_end_of_word) begin
          if (r_hold_full) begin
            // Queued word follows without a gap. ld_ready is low here,
            // so no accept can collide with this transfer.
            w_shift_nxt     = r_hold;
            w_hold_full_nxt = 1'b0;
            w_bitcnt_nxt    = '0;
          end else if (w_accept) begin
            // Word arriving exactly on the last edge bypasses the hold.
            w_shift_nxt  = ld_data;
            w_bitcnt_nxt = '0;
          end else begin
            w_shift_nxt  = '0;
            w_bitcnt_nxt = '0;
            w_state_nxt  = S_IDLE;
          end
        end else begin
          w_shift_nxt  = w_shift_adv;
          w_bitcnt_nxt = r_bitcnt + CW'(1);
          if (w_accept) begin
            w_hold_nxt      = ld_data;
            w_hold_full_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
    end
  end

  // Output registers are loaded from the next-state values so they line
  // up with the state they describe; dout is forced low outside a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_last       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_dout       <= (w_state_nxt == S_SHIFT) & w_head_nxt;
      r_dout_valid <= (w_state_nxt == S_SHIFT);
      r_last       <= (w_state_nxt == S_SHIFT) && (w_bitcnt_nxt == LAST_CNT);
      r_busy       <= (w_state_nxt == S_SHIFT) | w_hold_full_nxt;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign last       = r_last;
  assign busy       = r_busy;

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-to-serial transmitter for the serial bit-stream domain. A producer hands it WIDTH-bit words over a valid/ready handshake.
- It shifts each word out on a one-bit dout line, one bit per clock, with a valid strobe. This line feeds the serial din input of the team's sequence-detector FSMs.
- A one-deep holding register allows back-to-back words to stream with no idle gap.

Parameters:
- WIDTH, 11, bits per word; must be >= 2.
- MSB_FIRST, 0, 0 = ld_data[0] transmitted first; 1 = ld_data[WIDTH-1] transmitted first.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- ld_valid  input  1  producer has a word on ld_data.
- ld_data  input  WIDTH  word to transmit; sampled only on the accept edge.
- ld_ready  output  1  block can accept a word this cycle.
- dout  output  1  current serial bit.
- dout_valid  output  1  dout carries a frame bit this cycle.
- last  output  1  dout is the final bit of the current word.
- busy  output  1  transmitting, or a word is held pending.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; shift register, bit counter and hold register cleared; hold_full=0.
  - Outputs: dout=0, dout_valid=0, last=0, busy=0, ld_ready=1.
- Reset mid-frame: the frame is aborted and the held word discarded. No partial completion after release.
- Accept: occurs on a rising edge where ld_valid=1 and ld_ready=1. ld_ready = !hold_full, decoded from registers with no combinational path from ld_valid.
- States: IDLE, SHIFT.
- IDLE:
  - On accept, the word loads directly into the shift register. bitcnt=0, go to SHIFT.
  - dout, dout_valid, last and busy are registered. On the accepting edge they become dout=first bit, dout_valid=1.
  - Latency: the first bit appears the cycle after the accept edge.
- SHIFT:
  - Each edge advances one bit; bitcnt increments 0..WIDTH-1.
  - last=1 exactly when bitcnt=WIDTH-1.
  - An accept during SHIFT writes the hold register; hold_full=1 and ld_ready=0 from the next cycle.
- End of word (edge while bitcnt=WIDTH-1):
  - If hold_full: move hold into the shift register, hold_full=0, bitcnt=0, stay in SHIFT. Next cycle dout = new first bit with no gap.
  - Else if an accept happens on this same edge (hold empty): bypass the word straight into the shift register and stay in SHIFT, gapless.
  - Else: go to IDLE with dout=0, dout_valid=0, last=0.
- Simultaneous hold-to-shift transfer and new accept on the same edge:
  - Cannot occur, because ld_ready=0 while hold_full.
  - ld_ready returns to 1 the cycle after the transfer.
- Bit order:
  - MSB_FIRST=0: bits ld_data[0], [1], ..., [WIDTH-1].
  - MSB_FIRST=1: bits ld_data[WIDTH-1] down to [0].
- busy = (state==SHIFT) | hold_full.
- dout=0 whenever dout_valid=0.
- ld_data changes after the accept edge do not affect the word in flight or the held word.

Test Plan:
1. Assert reset=0 at t=0, then release -> dout=0, dout_valid=0, last=0, busy=0, ld_ready=1 during reset and after release with ld_valid=0.
2. WIDTH=11, MSB_FIRST=0: one accept of 11'b10101001010 -> dout = 0,1,0,1,0,0,1,0,1,0,1 on 11 consecutive cycles starting the cycle after accept. dout_valid high for exactly 11 cycles, last high only on cycle 11, then IDLE with busy=0.
3. Second word 11'b11111111111 offered at cycle 3 of the first frame:
   - Accepted, ld_ready=0 until the end of the first word.
   - 22 contiguous dout_valid cycles; bits 12-22 all 1; last pulses on cycles 11 and 22.
4. Third word held on ld_valid while hold is full:
   - No accept while ld_ready=0.
   - Accepted on the first edge ld_ready=1, i.e. the cycle after the hold-to-shift transfer.
   - Transmitted gaplessly after word 2, all 33 bits in order.
5. reset=0 asserted asynchronously between edges during bit 5, with a word held:
   - All outputs 0 immediately.
   - After release: ld_ready=1, busy=0, no residual bits from either word.
6. MSB_FIRST=1, word 11'b10000000011 -> dout = 1,0,0,0,0,0,0,0,0,1,1. Single-cycle bypass at the end-of-word edge gives no gap when the next word arrives exactly on that edge.
